data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single data-RAM port between two requesters.
- The core requester is the datapath load/store path (alu_r address, write_data, read_data return). The loader requester is the debug/program-load port.
- Round-robin arbitration, req/ready handshake toward both requesters, and support for a variable-latency memory with a timeout.
- Sits between the datapath, the loader and the data RAM. The core stalls while c_ready is low.

Parameters:
- AW, 16, address width (matches the 16-bit RAM/PC address space)
- DW, 32, data width
- TIMEOUT, 15, max BUSY cycles waiting for m_ready before aborting (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- c_req  in  1  core request, level; held until c_ready
- c_we  in  1  core write enable (1 = store, 0 = load)
- c_addr  in  AW  core address
- c_wdata  in  DW  core store data
- c_rdata  out  DW  core load data, valid when c_ready=1
- c_ready  out  1  core completion pulse, 1 cycle
- l_req, l_we, l_addr, l_wdata, l_rdata, l_ready  same as the core set, for the loader
- err  out  1  1-cycle pulse with ready when the access timed out
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid with m_ready
- m_ready  in  1  memory done; may assert in the first BUSY cycle

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; last_grant=LOADER, so the core wins the first tie; cnt=0.
- All outputs are registered or decoded from state and latched registers only. No combinational path from c_*/l_* to m_*.
- FSM has three states.
- IDLE:
  - No req: stay.
  - Only one req: grant it.
  - Both req: grant the requester that is not last_grant.
  - On grant: latch owner, we, addr, wdata; update last_grant; cnt=0; go BUSY.
- BUSY:
  - m_en=1; m_we/m_addr/m_wdata come from the latched values, stable for the whole state.
  - m_ready=1: capture m_rdata (reads only; writes capture 0); go RESP.
  - m_ready=0 and cnt==TIMEOUT-1: capture 0; set err_pending; go RESP.
  - Otherwise cnt++.
- RESP:
  - m_en=0; the owner's ready=1; the owner's rdata=captured value; err=err_pending.
  - Go IDLE; clear err_pending.
  - The non-owner's ready stays 0. Its rdata holds its previous value.
- Latency with zero-wait memory (m_ready in the first BUSY cycle):
  - req sampled at edge N.
  - BUSY during cycle N+1.
  - ready during cycle N+2.
  - Minimum 3 cycles per access including IDLE.
- Requester rule: deassert req in the cycle after ready, or present a new request. req still high in IDLE is a new access. That is legal back-to-back; under contention round-robin alternates.
- Request signals changing during BUSY/RESP have no effect; they are latched at grant only.
- A req dropped before grant is simply not served. There is no abort after grant.
- Reset mid-BUSY: m_en drops immediately, no ready is issued, and the access is lost.
- cnt width is 8 bits; no wrap occurs because TIMEOUT≤255.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2
  - owner encoding: CORE=1'b0, LOADER=1'b1
  - default TIMEOUT constant
- One natural sub-module: rr_arbiter2, a combinational 2-way round-robin pick from the two reqs and last_grant, producing grant and valid.
- Timeout counter and FSM stay in the top module.

Test Plan:
- Core load, zero-wait: c_req=1, c_we=0, c_addr=16'h0040, m_ready tied 1, m_rdata=32'hCAFE0001 -> m_en high exactly 1 cycle with m_addr=16'h0040, then c_ready=1 with c_rdata=32'hCAFE0001; l_ready stays 0; err=0.
- Loader store with 3 wait states: l_req=1, l_we=1, l_addr=16'h0100, l_wdata=32'h12345678, m_ready asserted in the 4th BUSY cycle -> m_en/m_we high 4 cycles with stable addr/data, then l_ready pulse 1 cycle; total 6 cycles from req.
- Contention: c_req and l_req both held high for 4 accesses starting after reset -> grant order CORE, LOADER, CORE, LOADER; each ready appears 3 cycles apart with zero-wait memory.
- Timeout: core load with m_ready held 0, TIMEOUT=15 -> m_en high exactly 15 cycles, then c_ready=1, err=1, c_rdata=0; the next access proceeds normally with err=0.
- Async reset mid-BUSY: assert rst 2 cycles into a 5-wait access -> m_en, c_ready, l_ready, err go 0 without a clock edge. After release, with both reqs high, CORE is granted first.
- Late request change: change c_addr from 16'h0010 to 16'h0020 during BUSY -> m_addr stays 16'h0010 until RESP.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_pkg
// Shared definitions for the data-RAM arbiter:
//   state_t  - arbiter FSM state encoding (IDLE, BUSY, RESP)
//   owner_t  - requester identity (CORE, LOADER)
//   TIMEOUT_DEFAULT - default number of BUSY cycles before an access aborts
//   CNT_W    - width of the BUSY-cycle counter
// -----------------------------------------------------------------------------
package data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      CORE   = 1'b0,
      LOADER = 1'b1
   } owner_t;

   localparam int unsigned TIMEOUT_DEFAULT = 32'd15;

   // TIMEOUT is limited to 255, so an 8-bit counter never wraps.
   localparam int unsigned CNT_W = 32'd8;

   // Returns the requester that did not win the last arbitration.
   function automatic owner_t other_owner(input owner_t who);
      owner_t res;
      if (who == CORE) begin
         res = LOADER;
      end else begin
         res = CORE;
      end
      return res;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin pick.
//   req_core    in  core request
//   req_loader  in  loader request
//   last_grant  in  requester granted most recently
//   grant       out selected requester (meaningful when valid=1)
//   valid       out at least one request is present
// On a tie the requester that did not win last time is chosen.
// -----------------------------------------------------------------------------
module rr_arbiter2
   import data_mem_arbiter_pkg::*;
(
   input  logic   req_core,
   input  logic   req_loader,
   input  owner_t last_grant,
   output owner_t grant,
   output logic   valid
);

   // Round-robin selection between the two requests
   always_comb begin
      grant = CORE;
      valid = 1'b0;
      case ({req_core, req_loader})
         2'b10: begin
            grant = CORE;
            valid = 1'b1;
         end
         2'b01: begin
            grant = LOADER;
            valid = 1'b1;
         end
         2'b11: begin
            grant = other_owner(last_grant);
            valid = 1'b1;
         end
         default: begin
            grant = CORE;
            valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single data-RAM port between the core load/store path and the
// debug/program loader, with round-robin arbitration and a memory timeout.
//
// Parameters
//   AW       address width
//   DW       data width
//   TIMEOUT  BUSY cycles to wait for m_ready before aborting (1..255)
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   c_req/c_we/c_addr/c_wdata   core request, held until c_ready
//   c_rdata, c_ready            core load data and 1-cycle completion pulse
//   l_req/l_we/l_addr/l_wdata   loader request, held until l_ready
//   l_rdata, l_ready            loader load data and 1-cycle completion pulse
//   err                         1-cycle pulse with ready when the access timed out
//   m_en/m_we/m_addr/m_wdata    memory strobe, write enable, address, write data
//   m_rdata, m_ready            memory read data and done indication
//
// Every output comes from a flop; requester inputs only reach the memory port
// through the registers loaded at grant time.
// -----------------------------------------------------------------------------
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int unsigned AW      = 32'd16,
   parameter int unsigned DW      = 32'd32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic [DW-1:0] c_rdata,
   output logic          c_ready,

   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic [DW-1:0] l_rdata,
   output logic          l_ready,

   output logic          err,

   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ready
);

   // Counter value of the final BUSY cycle before the access is abandoned.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 32'd1);

   state_t             state_r;
   owner_t             owner_r;
   owner_t             last_grant_r;
   logic [CNT_W-1:0]   cnt_r;

   logic               m_en_r;
   logic               m_we_r;
   logic [AW-1:0]      m_addr_r;
   logic [DW-1:0]      m_wdata_r;
   logic               c_ready_r;
   logic               l_ready_r;
   logic [DW-1:0]      c_rdata_r;
   logic [DW-1:0]      l_rdata_r;
   logic               err_r;

   owner_t             grant_s;
   logic               grant_valid_s;
   logic               sel_we_s;
   logic [AW-1:0]      sel_addr_s;
   logic [DW-1:0]      sel_wdata_s;
   logic [DW-1:0]      cap_data_s;

   rr_arbiter2 u_rr_arbiter2 (
      .req_core   (c_req),
      .req_loader (l_req),
      .last_grant (last_grant_r),
      .grant      (grant_s),
      .valid      (grant_valid_s)
   );

   // Request fields of the requester that would be granted this cycle
   always_comb begin
      sel_we_s    = 1'b0;
      sel_addr_s  = {AW{1'b0}};
      sel_wdata_s = {DW{1'b0}};
      if (grant_s == LOADER) begin
         sel_we_s    = l_we;
         sel_addr_s  = l_addr;
         sel_wdata_s = l_wdata;
      end else begin
         sel_we_s    = c_we;
         sel_addr_s  = c_addr;
         sel_wdata_s = c_wdata;
      end
   end

   // Data returned on a successful access: stores return zero
   always_comb begin
      cap_data_s = {DW{1'b0}};
      if (m_we_r) begin
         cap_data_s = {DW{1'b0}};
      end else begin
         cap_data_s = m_rdata;
      end
   end

   // Arbiter FSM, latched request, timeout counter and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         owner_r      <= CORE;
         last_grant_r <= LOADER;
         cnt_r        <= {CNT_W{1'b0}};
         m_en_r       <= 1'b0;
         m_we_r       <= 1'b0;
         m_addr_r     <= {AW{1'b0}};
         m_wdata_r    <= {DW{1'b0}};
         c_ready_r    <= 1'b0;
         l_ready_r    <= 1'b0;
         c_rdata_r    <= {DW{1'b0}};
         l_rdata_r    <= {DW{1'b0}};
         err_r        <= 1'b0;
      end else begin
         // Completion and error indications are single-cycle pulses.
         c_ready_r <= 1'b0;
         l_ready_r <= 1'b0;
         err_r     <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_valid_s) begin
                  owner_r      <= grant_s;
                  last_grant_r <= grant_s;
                  m_en_r       <= 1'b1;
                  m_we_r       <= sel_we_s;
                  m_addr_r     <= sel_addr_s;
                  m_wdata_r    <= sel_wdata_s;
                  cnt_r        <= {CNT_W{1'b0}};
                  state_r      <= BUSY;
               end else begin
                  state_r      <= IDLE;
               end
            end
            BUSY: begin
               if (m_ready || (cnt_r == LAST_CNT)) begin
                  // Access ends: hand the result to the owner next cycle.
                  m_en_r  <= 1'b0;
                  m_we_r  <= 1'b0;
                  err_r   <= ~m_ready;
                  state_r <= RESP;
                  if (owner_r == LOADER) begin
                     l_ready_r <= 1'b1;
                     l_rdata_r <= m_ready ? cap_data_s : {DW{1'b0}};
                  end else begin
                     c_ready_r <= 1'b1;
                     c_rdata_r <= m_ready ? cap_data_s : {DW{1'b0}};
                  end
               end else begin
                  cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  state_r <= BUSY;
               end
            end
            RESP: begin
               state_r <= IDLE;
            end
            default: begin
               // Unreachable encoding: park safely with the memory idle.
               m_en_r  <= 1'b0;
               m_we_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign m_en    = m_en_r;
   assign m_we    = m_we_r;
   assign m_addr  = m_addr_r;
   assign m_wdata = m_wdata_r;
   assign c_ready = c_ready_r;
   assign l_ready = l_ready_r;
   assign c_rdata = c_rdata_r;
   assign l_rdata = l_rdata_r;
   assign err     = err_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter. A transaction-level model tracks each
// access by cycle number (start cycle, last memory cycle, answer cycle) and a
// negedge process compares every DUT output against it. Literal expectations
// per scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   localparam int AW      = 16;
   localparam int DW      = 32;
   localparam int TIMEOUT = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          c_req, c_we, l_req, l_we;
   logic [AW-1:0] c_addr, l_addr;
   logic [DW-1:0] c_wdata, l_wdata;
   logic [DW-1:0] c_rdata, l_rdata;
   logic          c_ready, l_ready, err;
   logic          m_en, m_we, m_ready;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int mem_wait = 0;   // memory answers in BUSY cycle number mem_wait (0-based)

   data_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_ready(c_ready),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_rdata(l_rdata), .l_ready(l_ready),
      .err(err),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   // ---------------- model: one access at a time, described by cycle numbers
   int            cyc;          // index of the current clock cycle since reset
   bit            act;          // an access is in flight
   int            a_start;      // first cycle the memory is strobed
   int            a_end;        // last strobed cycle, -1 while unknown
   bit            a_owner;      // 0 core, 1 loader
   bit            a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata, a_data;
   bit            a_err;
   bit            last_owner;
   logic [DW-1:0] h_c_rdata, h_l_rdata;

   task automatic mdl_reset();
      cyc = 0; act = 0; a_start = 0; a_end = -1; a_owner = 0; a_we = 0;
      a_addr = '0; a_wdata = '0; a_data = '0; a_err = 0;
      last_owner = 1; h_c_rdata = '0; h_l_rdata = '0;
   endtask

   function automatic bit mdl_en();
      return act && (cyc >= a_start) && (a_end < 0 || cyc <= a_end);
   endfunction

   function automatic bit mdl_resp();
      return act && (a_end >= 0) && (cyc == a_end + 1);
   endfunction

   // Advance the model over the cycle that just ended at this rising edge.
   task automatic mdl_step();
      int c;
      c = cyc;
      cyc = cyc + 1;
      if (act && a_end < 0 && c >= a_start) begin
         if (m_ready) begin
            a_end = c; a_err = 0;
            a_data = a_we ? '0 : m_rdata;
         end else if (c - a_start == TIMEOUT - 1) begin
            a_end = c; a_err = 1; a_data = '0;
         end
         if (a_end >= 0) begin
            if (a_owner) h_l_rdata = a_data;
            else         h_c_rdata = a_data;
         end
      end else if (act && a_end >= 0 && c == a_end + 1) begin
         act = 0;
      end else if (!act && (c_req || l_req)) begin
         a_owner = (c_req && l_req) ? !last_owner : l_req;
         last_owner = a_owner;
         a_we    = a_owner ? l_we    : c_we;
         a_addr  = a_owner ? l_addr  : c_addr;
         a_wdata = a_owner ? l_wdata : c_wdata;
         a_start = cyc; a_end = -1; act = 1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // One clock: model update at the edge, memory response driven just after.
   task automatic tick();
      @(posedge clk);
      if (!rst) mdl_step();
      #1;
      m_ready = mdl_en() && ((cyc - a_start) == mem_wait);
   endtask

   // Compare every DUT output against the model, away from the active edge
   always @(negedge clk) begin
      check("m_en", m_en, mdl_en());
      if (mdl_en()) begin
         check("m_we", m_we, a_we);
         check("m_addr", m_addr, a_addr);
         check("m_wdata", m_wdata, a_wdata);
      end
      check("c_ready", c_ready, mdl_resp() && !a_owner);
      check("l_ready", l_ready, mdl_resp() && a_owner);
      check("err", err, mdl_resp() && a_err);
      check("c_rdata", c_rdata, h_c_rdata);
      check("l_rdata", l_rdata, h_l_rdata);
   end

   task automatic do_reset();
      rst = 1'b1; m_ready = 1'b0; mdl_reset();
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   // Tick until some ready appears; report latency, strobe count and result.
   task automatic wait_ready(input int budget, input logic [AW-1:0] exp_addr,
                             output int ticks, output int men_cnt, output logic who,
                             output logic [DW-1:0] rd, output logic e, output logic aok);
      bit done;
      done = 0; ticks = 0; men_cnt = 0; who = 0; rd = '0; e = 0; aok = 1;
      while (!done) begin
         tick();
         ticks++;
         if (m_en) begin
            men_cnt++;
            if (m_addr !== exp_addr) aok = 0;
         end
         if (c_ready || l_ready) begin
            who = l_ready; rd = l_ready ? l_rdata : c_rdata; e = err; done = 1;
         end else if (ticks >= budget) begin
            check("ready_within_budget", 32'd0, 32'd1);
            done = 1;
         end
      end
   endtask

   // Drop both requests in the ready cycle and move into the following idle cycle.
   task automatic release_reqs();
      c_req = 0; l_req = 0;
      tick();
   endtask

   initial begin
      int t, mc;
      logic who, e, aok;
      logic [DW-1:0] rd;
      c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
      m_ready = 0; m_rdata = '0;
      rst = 1'b0;
      #1;
      do_reset();
      check("reset_m_en", m_en, 32'd0);
      check("reset_c_ready", c_ready, 32'd0);
      check("reset_c_rdata", c_rdata, 32'd0);

      // Core load, zero-wait memory
      mem_wait = 0; m_rdata = 32'hCAFE0001;
      c_req = 1; c_we = 0; c_addr = 16'h0040;
      wait_ready(20, 16'h0040, t, mc, who, rd, e, aok);
      check("load_latency", t, 32'd2);
      check("load_men_cycles", mc, 32'd1);
      check("load_owner", who, 32'd0);
      check("load_rdata", rd, 32'hCAFE0001);
      check("load_err", e, 32'd0);
      release_reqs();

      // Loader store, three wait states
      mem_wait = 3; m_rdata = 32'h0BAD0BAD;
      l_req = 1; l_we = 1; l_addr = 16'h0100; l_wdata = 32'h12345678;
      wait_ready(20, 16'h0100, t, mc, who, rd, e, aok);
      check("store_latency", t, 32'd5);
      check("store_men_cycles", mc, 32'd4);
      check("store_addr_stable", aok, 32'd1);
      check("store_owner", who, 32'd1);
      check("store_rdata_zero", rd, 32'd0);
      release_reqs();

      // Timeout, then a normal access
      mem_wait = 1000; m_rdata = 32'hDEADBEEF;
      c_req = 1; c_we = 0; c_addr = 16'h0044;
      wait_ready(40, 16'h0044, t, mc, who, rd, e, aok);
      check("timeout_men_cycles", mc, 32'd15);
      check("timeout_latency", t, 32'd16);
      check("timeout_err", e, 32'd1);
      check("timeout_rdata", rd, 32'd0);
      release_reqs();
      mem_wait = 0; m_rdata = 32'h11112222;
      c_req = 1; c_addr = 16'h0048;
      wait_ready(20, 16'h0048, t, mc, who, rd, e, aok);
      check("after_timeout_err", e, 32'd0);
      check("after_timeout_rdata", rd, 32'h11112222);
      release_reqs();

      // Request fields changing during BUSY are ignored
      mem_wait = 3; m_rdata = 32'hABCD0010;
      c_req = 1; c_we = 0; c_addr = 16'h0010; c_wdata = '0;
      tick();
      check("late_first_men", m_en, 32'd1);
      check("late_first_addr", m_addr, 32'h0010);
      c_addr = 16'h0020; c_we = 1; c_wdata = 32'hFFFF0000;
      wait_ready(20, 16'h0010, t, mc, who, rd, e, aok);
      check("late_addr_held", aok, 32'd1);
      check("late_remaining_men", mc, 32'd3);
      check("late_rdata", rd, 32'hABCD0010);
      release_reqs();
      c_we = 0;

      // Contention after reset: CORE, LOADER, CORE, LOADER, 3 cycles apart
      do_reset();
      mem_wait = 0; m_rdata = 32'h55550000;
      c_req = 1; l_req = 1; c_addr = 16'h0200; l_addr = 16'h0300; l_we = 0;
      for (int i = 0; i < 4; i++) begin
         wait_ready(20, (i % 2 == 0) ? 16'h0200 : 16'h0300, t, mc, who, rd, e, aok);
         check("rr_owner", who, i % 2);
         check("rr_spacing", t, (i == 0) ? 32'd2 : 32'd3);
      end
      release_reqs();

      // Asynchronous reset two cycles into a five-wait access
      mem_wait = 5;
      c_req = 1; c_addr = 16'h0080;
      tick();
      tick();
      check("pre_reset_men", m_en, 32'd1);
      #2;
      rst = 1'b1; m_ready = 1'b0; mdl_reset();
      #1;
      check("async_rst_m_en", m_en, 32'd0);
      check("async_rst_c_ready", c_ready, 32'd0);
      check("async_rst_l_ready", l_ready, 32'd0);
      check("async_rst_err", err, 32'd0);
      mem_wait = 0;
      c_req = 1; l_req = 1; c_addr = 16'h0084; l_addr = 16'h0304;
      @(negedge clk);
      #2;
      rst = 1'b0;
      wait_ready(20, 16'h0084, t, mc, who, rd, e, aok);
      check("post_reset_owner", who, 32'd0);
      check("post_reset_latency", t, 32'd2);
      release_reqs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
